// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register for the RV32I core.
// Decodes a fetched instruction into the ALU operation code and both ALU
// operands, and holds the result in a valid/ready pipeline register that
// feeds the execute-stage ALU. Also provides stall, flush and a counter of
// ops consumed by execute.
//
// Optional feature, macro ALU_ISSUE_ILLEGAL_EN: adds an `illegal` flag that is
// registered with the op, and a sticky `illegal_seen` flag that is set when an
// illegal op is consumed. Without the macro, undefined encodings issue
// silently as ADD 0+0 with no register write.

module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  operand_a,
  output logic [XLEN-1:0]  operand_b,
  output logic [3:0]       alu_control,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic [CNT_W-1:0] issue_count
`ifdef ALU_ISSUE_ILLEGAL_EN
  , output logic           illegal
  , output logic           illegal_seen
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_JALR = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared funct3 map of OP and OP-IMM; `alt` selects SUB/SRA.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [3:0]      dec_alu;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_wr_raw;
  logic            dec_ill;
  logic [4:0]      dec_rd;
  logic            dec_we;

  // Instruction decode; every illegal path leaves the ADD 0+0, no-write default.
  always_comb begin
    dec_alu    = ALU_ADD;
    dec_a      = '0;
    dec_b      = '0;
    dec_wr_raw = 1'b0;
    dec_ill    = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_alu    = f3_to_alu(funct3, funct7[5]);
          dec_a      = rs1_data;
          dec_b      = rs2_data;
          dec_wr_raw = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != F7_BASE) ||
            (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)) begin
          dec_ill = 1'b1;
        end else begin
          dec_a      = rs1_data;
          dec_wr_raw = 1'b1;
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            // Shift amount only; the funct7 bits of the I-immediate are not part of b.
            dec_alu = f3_to_alu(funct3, instr[30]);
            dec_b   = {{(XLEN-5){1'b0}}, instr[24:20]};
          end else begin
            dec_alu = f3_to_alu(funct3, 1'b0);
            dec_b   = imm_i;
          end
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec_ill = 1'b1;
        end else begin
          dec_a      = rs1_data;
          dec_b      = imm_i;
          dec_wr_raw = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3[2] || funct3 == 3'b011) begin
          dec_ill = 1'b1;
        end else begin
          dec_a = rs1_data;
          dec_b = imm_s;
        end
      end
      OPC_LUI: begin
        dec_b      = imm_u;
        dec_wr_raw = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a      = pc;
        dec_b      = imm_u;
        dec_wr_raw = 1'b1;
      end
      OPC_JAL: begin
        dec_a      = pc;
        dec_b      = imm_j;
        dec_wr_raw = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) begin
          dec_ill = 1'b1;
        end else begin
          dec_alu    = ALU_JALR;
          dec_a      = rs1_data;
          dec_b      = imm_i;
          dec_wr_raw = 1'b1;
        end
      end
      OPC_BRANCH: begin
        // The branch offset is not an ALU operand here; the comparison uses rs1/rs2.
        if (funct3 == 3'b010 || funct3 == 3'b011 || imm_b[0]) begin
          dec_ill = 1'b1;
        end else begin
          dec_a = rs1_data;
          dec_b = rs2_data;
          case (funct3[2:1])
            2'b00:   dec_alu = ALU_SUB;
            2'b10:   dec_alu = ALU_SLT;
            default: dec_alu = ALU_SLTU;
          endcase
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_we = dec_wr_raw && (instr[11:7] != 5'd0);
  assign dec_rd = dec_we ? instr[11:7] : 5'd0;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]       alu_q, alu_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, consume;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready && !flush;

  // Next-state of the issue register: flush wins, then accept, then consume.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    we_d    = we_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      alu_d   = dec_alu;
      rd_d    = dec_rd;
      we_d    = dec_we;
    end else if (consume) begin
      valid_d = 1'b0;
    end
    cnt_d = consume ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Issue register and consume counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign alu_control = alu_q;
  assign rd          = rd_q;
  assign reg_write   = we_q;
  assign issue_count = cnt_q;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic ill_q, seen_q;

  // Illegal flag travels with the op; the sticky flag records any consumed illegal op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      if (!flush && accept) ill_q <= dec_ill;
      if (consume && ill_q) seen_q <= 1'b1;
    end
  end

  assign illegal      = ill_q;
  assign illegal_seen = seen_q;
`else
  logic unused_ill;
  assign unused_ill = dec_ill;
`endif

endmodule
